// File: rtl/fadd_issue_ctrl.sv
// Issue/retire front end for a fixed-latency pipelined FP adder.
// Credits guarantee every in-flight result has a slot in the response FIFO.
module fadd_issue_ctrl #(
    parameter int LATENCY    = 4,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fadd_a,
    output logic [31:0]      fadd_b,
    output logic             fadd_op,
    input  logic [31:0]      fadd_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    logic [LATENCY-1:0] trk_vld_r;
    logic [TAG_W-1:0]   trk_tag_r [LATENCY];
    logic [INF_W-1:0]   inflight_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [31:0]        res_mem_r [FIFO_DEPTH];
    logic [TAG_W-1:0]   tag_mem_r [FIFO_DEPTH];

    logic               push_s;
    logic               pop_s;
    logic               accept_s;
    logic               req_ready_s;
    logic               rsp_valid_s;
    logic [SUM_W-1:0]   credit_sum_s;

    // Handshake and credit decode from registered state only
    always_comb begin
        push_s       = trk_vld_r[LATENCY-1];
        rsp_valid_s  = (count_r != {CNT_W{1'b0}});
        pop_s        = rsp_valid_s & rsp_ready;
        credit_sum_s = SUM_W'(inflight_r) + SUM_W'(count_r);
        // A pop this cycle is deliberately not credited until it has happened
        req_ready_s  = rst & (credit_sum_s < SUM_W'(FIFO_DEPTH));
        accept_s     = req_valid & req_ready_s;
    end

    // Operand registers feeding the adder; held when nothing is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fadd_a  <= 32'h0000_0000;
            fadd_b  <= 32'h0000_0000;
            fadd_op <= 1'b0;
        end else if (accept_s) begin
            fadd_a  <= req_a;
            fadd_b  <= req_b;
            fadd_op <= req_op;
        end else begin
            fadd_a  <= fadd_a;
            fadd_b  <= fadd_b;
            fadd_op <= fadd_op;
        end
    end

    // Tracker shift register mirroring the adder pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_vld_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                trk_tag_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            trk_vld_r[0] <= accept_s;
            trk_tag_r[0] <= accept_s ? req_tag : {TAG_W{1'b0}};
            for (int i = 1; i < LATENCY; i++) begin
                trk_vld_r[i] <= trk_vld_r[i-1];
                trk_tag_r[i] <= trk_tag_r[i-1];
            end
        end
    end

    // In-flight credit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= {INF_W{1'b0}};
        end else begin
            case ({accept_s, push_s})
                2'b10:   inflight_r <= inflight_r + INF_W'(1);
                2'b01:   inflight_r <= inflight_r - INF_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO occupancy and pointers; push and pop together leave count alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push_s) begin
            res_mem_r[wr_ptr_r] <= fadd_result;
            tag_mem_r[wr_ptr_r] <= trk_tag_r[LATENCY-1];
        end
    end

    // Head of FIFO, forced to zero when empty so reset shows a clean bus
    always_comb begin
        rsp_result = 32'h0000_0000;
        rsp_tag    = {TAG_W{1'b0}};
        if (rsp_valid_s) begin
            rsp_result = res_mem_r[rd_ptr_r];
            rsp_tag    = tag_mem_r[rd_ptr_r];
        end else begin
            rsp_result = 32'h0000_0000;
            rsp_tag    = {TAG_W{1'b0}};
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign busy      = (inflight_r != {INF_W{1'b0}}) | rsp_valid_s;

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Directed bench for fadd_issue_ctrl with a behavioural 4-cycle adder stand-in.
module tb_fadd_issue_ctrl;

    localparam int LAT   = 4;
    localparam int TW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_a = 32'h0;
    logic [31:0]   req_b = 32'h0;
    logic          req_op = 1'b0;
    logic [TW-1:0] req_tag = '0;
    logic [31:0]   fadd_a;
    logic [31:0]   fadd_b;
    logic          fadd_op;
    logic [31:0]   fadd_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    fadd_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_op(fadd_op),
        .fadd_result(fadd_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in adder: known operand pairs give their IEEE sums, others a fixed scramble
    function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic op);
        if (!op && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        else if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        else if (op && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        else return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
    endfunction

    logic [31:0] pipe_r [LAT-1];
    always @(posedge clk) begin
        pipe_r[0] <= fadd_ref(fadd_a, fadd_b, fadd_op);
        for (int i = 1; i < LAT - 1; i++) pipe_r[i] <= pipe_r[i-1];
    end
    assign fadd_result = pipe_r[LAT-2];

    // Occupancy model used to flag any push into a full FIFO
    logic [LAT-1:0] m_trk;
    int             m_occ;
    int             m_ovf = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_trk <= '0;
            m_occ <= 0;
        end else begin
            m_trk <= {m_trk[LAT-2:0], req_valid & req_ready};
            if (m_trk[LAT-1] && !(rsp_valid && rsp_ready) && m_occ >= DEPTH) m_ovf <= m_ovf + 1;
            m_occ <= m_occ + (m_trk[LAT-1] ? 1 : 0) - ((rsp_valid && rsp_ready) ? 1 : 0);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [TW-1:0] tag);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
    endtask

    int n_acc;

    initial begin
        #2 rst = 1'b0;
        tick();
        chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_fadd_a", fadd_a, 32'd0);
        chk_eq("rst_rsp_result", rsp_result, 32'd0);
        chk_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk_eq("rel_req_ready", 32'(req_ready), 32'd1);

        // Single op
        drive(1'b1, 32'h3FC00000, 32'h40100000, 1'b0, 4'd3);
        tick();
        req_valid = 1'b0;
        chk_eq("t1_fadd_a", fadd_a, 32'h3FC00000);
        chk_eq("t1_fadd_b", fadd_b, 32'h40100000);
        chk_eq("t1_fadd_op", 32'(fadd_op), 32'd0);
        chk_eq("t1_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        chk_eq("t1_early", 32'(rsp_valid), 32'd0);
        tick();
        chk_eq("t1_valid", 32'(rsp_valid), 32'd1);
        chk_eq("t1_result", rsp_result, 32'h40700000);
        chk_eq("t1_tag", 32'(rsp_tag), 32'd3);
        rsp_ready = 1'b1;
        tick();
        chk_eq("t1_popped", 32'(rsp_valid), 32'd0);
        chk_eq("t1_busy_fall", 32'(busy), 32'd0);

        // Streaming, rsp_ready still 1
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                if (i % 2 == 0) drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, TW'(i));
                else            drive(1'b1, 32'h40400000, 32'h3F800000, 1'b1, TW'(i));
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (i >= 4) begin
                chk_eq("t2_valid", 32'(rsp_valid), 32'd1);
                chk_eq("t2_tag", 32'(rsp_tag), 32'(i - 4));
                chk_eq("t2_result", rsp_result, 32'h40000000);
            end
        end
        tick();
        chk_eq("t2_empty", 32'(rsp_valid), 32'd0);
        chk_eq("t2_hold_a", fadd_a, 32'h40400000);
        chk_eq("t2_hold_op", 32'(fadd_op), 32'd1);

        // Backpressure
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h41000000 | n_acc, 32'h3F000000 + n_acc, n_acc[0], TW'(n_acc));
            if (req_ready) n_acc++;
            tick();
        end
        req_valid = 1'b0;
        chk_eq("t3_accepts", 32'(n_acc), 32'd8);
        chk_eq("t3_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk_eq("t3_valid", 32'(rsp_valid), 32'd1);
            chk_eq("t3_tag", 32'(rsp_tag), 32'(k));
            chk_eq("t3_result", rsp_result, fadd_ref(32'h41000000 | k, 32'h3F000000 + k, k[0]));
            tick();
            if (k == 0) chk_eq("t3_ready_back", 32'(req_ready), 32'd1);
        end
        chk_eq("t3_empty", 32'(rsp_valid), 32'd0);

        // Full FIFO with simultaneous push and pop
        rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h42000000 | i, 32'h3E000000 + i, 1'b0, TW'(i));
            tick();
        end
        req_valid = 1'b0;
        repeat (4) tick();
        chk_eq("t4_ready7", 32'(req_ready), 32'd1);
        drive(1'b1, 32'h42000007, 32'h3E000007, 1'b0, 4'd7);
        tick();
        req_valid = 1'b0;
        chk_eq("t4_ready8", 32'(req_ready), 32'd0);
        repeat (3) tick();
        chk_eq("t4_ready8b", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_eq("t4_ready_after", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            chk_eq("t4_valid", 32'(rsp_valid), 32'd1);
            chk_eq("t4_tag", 32'(rsp_tag), 32'(k));
            chk_eq("t4_result", rsp_result, fadd_ref(32'h42000000 | k, 32'h3E000000 + k, 1'b0));
            tick();
        end
        chk_eq("t4_empty", 32'(rsp_valid), 32'd0);

        // Bubbles
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'h9);
            else if (i == 2) drive(1'b1, 32'h3FC00000, 32'h40100000, 1'b0, 4'hA);
            else             req_valid = 1'b0;
            tick();
            chk_eq("t5_valid", 32'(rsp_valid), (i == 4 || i == 6) ? 32'd1 : 32'd0);
            if (i == 4) begin
                chk_eq("t5_tag9", 32'(rsp_tag), 32'h9);
                chk_eq("t5_res9", rsp_result, 32'h40000000);
            end
            if (i == 6) begin
                chk_eq("t5_tagA", 32'(rsp_tag), 32'hA);
                chk_eq("t5_resA", rsp_result, 32'h40700000);
            end
        end

        // Mid-flight reset: 2 queued, 3 in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, TW'(i));
            tick();
        end
        req_valid = 1'b0;
        tick();
        chk_eq("t6_pre_valid", 32'(rsp_valid), 32'd1);
        chk_eq("t6_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_eq("t6_req_ready", 32'(req_ready), 32'd0);
        chk_eq("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("t6_rsp_result", rsp_result, 32'd0);
        chk_eq("t6_rsp_tag", 32'(rsp_tag), 32'd0);
        chk_eq("t6_busy", 32'(busy), 32'd0);
        chk_eq("t6_fadd_a", fadd_a, 32'd0);
        chk_eq("t6_fadd_b", fadd_b, 32'd0);
        chk_eq("t6_fadd_op", 32'(fadd_op), 32'd0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk_eq("t6_rel_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk_eq("t6_quiet", {30'd0, rsp_valid, busy}, 32'd0);
        end
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'd5);
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk_eq("t6_early", 32'(rsp_valid), 32'd0);
        tick();
        chk_eq("t6_valid", 32'(rsp_valid), 32'd1);
        chk_eq("t6_tag", 32'(rsp_tag), 32'd5);
        chk_eq("t6_result", rsp_result, 32'h40000000);

        chk_eq("no_overflow", 32'(m_ovf), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
